// File: rtl/sprite_pkg.sv
// Shared types for the scanline sprite compositor: sprite geometry,
// FSM state encoding and the attribute table record.
package sprite_pkg;

  localparam int SPRITE_W_ENTRIES = 8;
  localparam int SPRITE_H_ROWS    = 16;
  localparam int ATTR_X_W         = 8;
  localparam int ATTR_Y_W         = 10;
  localparam int ATTR_NUM_W       = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCAN,
    ST_FETCH,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic                  en;
    logic [ATTR_X_W-1:0]   x;
    logic [ATTR_Y_W-1:0]   y;
    logic [ATTR_NUM_W-1:0] num;
  } attr_t;

  // Row offset of a sprite relative to the composed line, wrapping mod 2^10.
  function automatic logic [ATTR_Y_W-1:0] sprite_dy(input logic [ATTR_Y_W-1:0] line_y,
                                                    input logic [ATTR_Y_W-1:0] top_y);
    return line_y - top_y;
  endfunction

endpackage

// File: rtl/sprite_attr_table.sv
// Sprite attribute register file: one synchronous write port, one
// combinational read port, cleared (all sprites disabled) on reset.
module sprite_attr_table
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_SPRITES)-1:0] wr_idx,
  input  attr_t                          wr_data,
  input  logic [$clog2(NUM_SPRITES)-1:0] rd_idx,
  output attr_t                          rd_data
);

  attr_t [NUM_SPRITES-1:0] entries_q;
  attr_t [NUM_SPRITES-1:0] entries_d;

  always_comb begin
    entries_d = entries_q;
    if (wr_en) begin
      entries_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

  assign rd_data = entries_q[rd_idx];

endmodule

// File: rtl/sprite_line_composer.sv
// Scanline sprite compositor: clears one half of the ping-pong line buffer,
// then draws every sprite overlapping the requested row from the sprite ROM.
module sprite_line_composer
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 8,
  parameter int LB_DEPTH    = 256,
  parameter int LB_AW       = 8
) (
  input  logic                           i_Clk,
  input  logic                           i_Reset,
  input  logic                           i_Attr_We,
  input  logic [$clog2(NUM_SPRITES)-1:0] i_Attr_Idx,
  input  logic                           i_Attr_En,
  input  logic [LB_AW-1:0]               i_Attr_X,
  input  logic [9:0]                     i_Attr_Y,
  input  logic [5:0]                     i_Attr_Num,
  input  logic                           i_Line_Start,
  input  logic [9:0]                     i_Line_Y,
  input  logic                           i_Buf_Sel,
  output logic [5:0]                     o_Rom_Sprite,
  output logic [2:0]                     o_Rom_Row,
  output logic [2:0]                     o_Rom_Col,
  input  logic [1:0]                     i_Rom_Pixel,
  output logic                           o_Lb_We,
  output logic [LB_AW:0]                 o_Lb_Addr,
  output logic [1:0]                     o_Lb_Data,
  output logic                           o_Busy,
  output logic                           o_Done,
  output logic                           o_Overrun
);

  localparam int IW = $clog2(NUM_SPRITES);

  attr_t attr_wr;
  attr_t attr_rd;

  assign attr_wr = '{en: i_Attr_En, x: i_Attr_X, y: i_Attr_Y, num: i_Attr_Num};

  state_e           state_q,      state_d;
  logic [9:0]       line_y_q,     line_y_d;
  logic             buf_sel_q,    buf_sel_d;
  logic [IW-1:0]    ptr_q,        ptr_d;
  logic [LB_AW-1:0] clr_cnt_q,    clr_cnt_d;
  logic [3:0]       fcnt_q,       fcnt_d;
  logic [LB_AW-1:0] fx_q,         fx_d;
  logic [5:0]       rom_sprite_q, rom_sprite_d;
  logic [2:0]       rom_row_q,    rom_row_d;
  logic [2:0]       rom_col_q,    rom_col_d;
  logic             lb_we_q,      lb_we_d;
  logic [LB_AW:0]   lb_addr_q,    lb_addr_d;
  logic [1:0]       lb_data_q,    lb_data_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;
  logic             overrun_q,    overrun_d;

  sprite_attr_table #(
    .NUM_SPRITES(NUM_SPRITES)
  ) u_attr_table (
    .clk     (i_Clk),
    .rst     (i_Reset),
    .wr_en   (i_Attr_We),
    .wr_idx  (i_Attr_Idx),
    .wr_data (attr_wr),
    .rd_idx  (ptr_q),
    .rd_data (attr_rd)
  );

  logic [9:0]     dy;
  logic           hit;
  logic [2:0]     pix_col;
  logic [LB_AW:0] pix_addr;

  // The pixel on i_Rom_Pixel during fetch step k belongs to column k-1.
  always_comb begin
    dy       = sprite_dy(line_y_q, attr_rd.y);
    hit      = attr_rd.en && (dy < 10'(SPRITE_H_ROWS));
    pix_col  = 3'(fcnt_q - 4'd1);
    pix_addr = {1'b0, fx_q} + (LB_AW+1)'(pix_col);
  end

  always_comb begin
    state_d      = state_q;
    line_y_d     = line_y_q;
    buf_sel_d    = buf_sel_q;
    ptr_d        = ptr_q;
    clr_cnt_d    = clr_cnt_q;
    fcnt_d       = fcnt_q;
    fx_d         = fx_q;
    rom_sprite_d = rom_sprite_q;
    rom_row_d    = rom_row_q;
    rom_col_d    = rom_col_q;
    lb_we_d      = 1'b0;
    lb_addr_d    = lb_addr_q;
    lb_data_d    = lb_data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    overrun_d    = overrun_q;

    if (i_Line_Start && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_Line_Start) begin
          line_y_d  = i_Line_Y;
          buf_sel_d = i_Buf_Sel;
          ptr_d     = IW'(NUM_SPRITES - 1);
          clr_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        lb_we_d   = 1'b1;
        lb_addr_d = {buf_sel_q, clr_cnt_q};
        lb_data_d = 2'd0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LB_AW'(LB_DEPTH - 1)) begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (hit) begin
          fcnt_d       = 4'd0;
          fx_d         = attr_rd.x;
          rom_sprite_d = attr_rd.num;
          rom_row_d    = dy[3:1];
          rom_col_d    = 3'd0;
          state_d      = ST_FETCH;
        end else if (ptr_q == '0) begin
          state_d = ST_DONE;
        end else begin
          ptr_d = ptr_q - 1'b1;
        end
      end
      ST_FETCH: begin
        if (fcnt_q < 4'd7) begin
          rom_col_d = rom_col_q + 1'b1;
        end
        if (fcnt_q != 4'd0) begin
          lb_we_d   = (i_Rom_Pixel != 2'd0) && !pix_addr[LB_AW];
          lb_addr_d = {buf_sel_q, pix_addr[LB_AW-1:0]};
          lb_data_d = i_Rom_Pixel;
        end
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_q == 4'd8) begin
          fcnt_d = 4'd0;
          if (ptr_q == '0) begin
            state_d = ST_DONE;
          end else begin
            ptr_d   = ptr_q - 1'b1;
            state_d = ST_SCAN;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q      <= ST_IDLE;
      line_y_q     <= '0;
      buf_sel_q    <= 1'b0;
      ptr_q        <= '0;
      clr_cnt_q    <= '0;
      fcnt_q       <= '0;
      fx_q         <= '0;
      rom_sprite_q <= '0;
      rom_row_q    <= '0;
      rom_col_q    <= '0;
      lb_we_q      <= 1'b0;
      lb_addr_q    <= '0;
      lb_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_y_q     <= line_y_d;
      buf_sel_q    <= buf_sel_d;
      ptr_q        <= ptr_d;
      clr_cnt_q    <= clr_cnt_d;
      fcnt_q       <= fcnt_d;
      fx_q         <= fx_d;
      rom_sprite_q <= rom_sprite_d;
      rom_row_q    <= rom_row_d;
      rom_col_q    <= rom_col_d;
      lb_we_q      <= lb_we_d;
      lb_addr_q    <= lb_addr_d;
      lb_data_q    <= lb_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_Rom_Sprite = rom_sprite_q;
  assign o_Rom_Row    = rom_row_q;
  assign o_Rom_Col    = rom_col_q;
  assign o_Lb_We      = lb_we_q;
  assign o_Lb_Addr    = lb_addr_q;
  assign o_Lb_Data    = lb_data_q;
  assign o_Busy       = busy_q;
  assign o_Done       = done_q;
  assign o_Overrun    = overrun_q;

endmodule

// File: tb/tb_sprite_line_composer.sv
// Bench for sprite_line_composer: registered ROM model, line-buffer capture,
// and a reference compositor working directly from the sprite drawing rules.
module tb_sprite_line_composer;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_Attr_We;
  logic [2:0] i_Attr_Idx;
  logic       i_Attr_En;
  logic [7:0] i_Attr_X;
  logic [9:0] i_Attr_Y;
  logic [5:0] i_Attr_Num;
  logic       i_Line_Start;
  logic [9:0] i_Line_Y;
  logic       i_Buf_Sel;
  logic [5:0] o_Rom_Sprite;
  logic [2:0] o_Rom_Row;
  logic [2:0] o_Rom_Col;
  logic [1:0] rom_pix;
  logic       o_Lb_We;
  logic [8:0] o_Lb_Addr;
  logic [1:0] o_Lb_Data;
  logic       o_Busy;
  logic       o_Done;
  logic       o_Overrun;

  always #5 clk = ~clk;

  sprite_line_composer dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Attr_We    (i_Attr_We),
    .i_Attr_Idx   (i_Attr_Idx),
    .i_Attr_En    (i_Attr_En),
    .i_Attr_X     (i_Attr_X),
    .i_Attr_Y     (i_Attr_Y),
    .i_Attr_Num   (i_Attr_Num),
    .i_Line_Start (i_Line_Start),
    .i_Line_Y     (i_Line_Y),
    .i_Buf_Sel    (i_Buf_Sel),
    .o_Rom_Sprite (o_Rom_Sprite),
    .o_Rom_Row    (o_Rom_Row),
    .o_Rom_Col    (o_Rom_Col),
    .i_Rom_Pixel  (rom_pix),
    .o_Lb_We      (o_Lb_We),
    .o_Lb_Addr    (o_Lb_Addr),
    .o_Lb_Data    (o_Lb_Data),
    .o_Busy       (o_Busy),
    .o_Done       (o_Done),
    .o_Overrun    (o_Overrun)
  );

  // Sprite ROM: data appears one clock after its address.
  logic [1:0] rom_img [64][8][8];
  always @(posedge clk) rom_pix <= rom_img[o_Rom_Sprite][o_Rom_Row][o_Rom_Col];

  // Line buffer capture and write statistics.
  logic [1:0] lb_mem [512];
  int         wr_cnt = 0;
  int         other_cnt = 0;
  int         low_nz = 0;
  logic       cur_sel = 1'b0;
  always @(negedge clk) begin
    if (o_Lb_We === 1'b1) begin
      lb_mem[o_Lb_Addr] = o_Lb_Data;
      wr_cnt++;
      if (o_Lb_Addr[8] !== cur_sel) other_cnt++;
      if (o_Lb_Data != 2'd0 && o_Lb_Addr[7:0] < 8'd4) low_nz++;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int w_base, o_base, l_base;

  // Shadow attribute table and reference line.
  bit sh_en [8];
  int sh_x [8];
  int sh_y [8];
  int sh_num [8];
  int exp_line [256];
  int exp_hits, exp_draw;

  function automatic void model_line(input int y);
    exp_hits = 0;
    exp_draw = 0;
    for (int e = 0; e < 256; e++) exp_line[e] = 0;
    for (int s = 7; s >= 0; s--) begin
      int dy;
      dy = ((y - sh_y[s]) % 1024 + 1024) % 1024;
      if (sh_en[s] && dy < 16) begin
        exp_hits++;
        for (int c = 0; c < 8; c++) begin
          int p;
          p = int'(rom_img[sh_num[s]][dy / 2][c]);
          if (p != 0 && sh_x[s] + c < 256) begin
            exp_line[sh_x[s] + c] = p;
            exp_draw++;
          end
        end
      end
    end
  endfunction

  function automatic int line_diff(input logic sel);
    int bad = 0;
    for (int e = 0; e < 256; e++)
      if (lb_mem[{sel, 8'(e)}] !== 2'(exp_line[e])) bad++;
    return bad;
  endfunction

  task automatic write_attr(input int idx, input bit en, input int x, input int y, input int num);
    @(negedge clk);
    i_Attr_We  = 1'b1;
    i_Attr_Idx = 3'(idx);
    i_Attr_En  = en;
    i_Attr_X   = 8'(x);
    i_Attr_Y   = 10'(y);
    i_Attr_Num = 6'(num);
    @(negedge clk);
    i_Attr_We = 1'b0;
    sh_en[idx] = en; sh_x[idx] = x; sh_y[idx] = y; sh_num[idx] = num;
  endtask

  task automatic disable_all();
    for (int i = 0; i < 8; i++) write_attr(i, 1'b0, 0, 0, 0);
  endtask

  // Starts a line and waits for o_Done; lat counts edges after the start edge.
  task automatic run_line(input int y, input logic sel, input int extra_at, output int lat);
    @(negedge clk);
    w_base = wr_cnt; o_base = other_cnt; l_base = low_nz;
    cur_sel = sel;
    i_Line_Y = 10'(y);
    i_Buf_Sel = sel;
    i_Line_Start = 1'b1;
    @(negedge clk);
    i_Line_Start = 1'b0;
    lat = 0;
    while (o_Done !== 1'b1 && lat < 2000) begin
      @(negedge clk);
      lat++;
      i_Line_Start = (lat == extra_at);
    end
    i_Line_Start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if (o_Busy !== 1'b0 || o_Done !== 1'b0 || o_Overrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_status busy=%b done=%b ovr=%b expected 0 0 0", o_Busy, o_Done, o_Overrun);
    end
    n_tests++;
    if (o_Lb_We !== 1'b0 || o_Lb_Addr !== 9'd0 || o_Lb_Data !== 2'd0) begin
      n_fail++; $display("FAIL reset_lb we=%b addr=%0d data=%0d expected 0", o_Lb_We, o_Lb_Addr, o_Lb_Data);
    end
    n_tests++;
    if (o_Rom_Sprite !== 6'd0 || o_Rom_Row !== 3'd0 || o_Rom_Col !== 3'd0) begin
      n_fail++; $display("FAIL reset_rom spr=%0d row=%0d col=%0d expected 0", o_Rom_Sprite, o_Rom_Row, o_Rom_Col);
    end
  endtask

  task automatic test_no_sprites();
    int lat;
    model_line(5);
    run_line(5, 1'b1, -1, lat);
    n_tests++;
    if (lat !== 265) begin n_fail++; $display("FAIL empty_latency got %0d expected 265", lat); end
    n_tests++;
    if (wr_cnt - w_base !== 256) begin n_fail++; $display("FAIL empty_writes got %0d expected 256", wr_cnt - w_base); end
    n_tests++;
    if (other_cnt - o_base !== 0) begin n_fail++; $display("FAIL empty_other_half got %0d expected 0", other_cnt - o_base); end
    n_tests++;
    if (line_diff(1'b1) !== 0) begin n_fail++; $display("FAIL empty_line bad_entries=%0d expected 0", line_diff(1'b1)); end
    n_tests++;
    if (o_Overrun !== 1'b0) begin n_fail++; $display("FAIL empty_overrun got %b expected 0", o_Overrun); end
  endtask

  task automatic test_row_select();
    int lat;
    int pat [8] = '{1, 2, 3, 0, 0, 1, 2, 3};
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) rom_img[3][r][c] = (r == 1) ? 2'(pat[c]) : 2'd3;
    write_attr(0, 1'b1, 10, 100, 3);
    model_line(102);
    run_line(102, 1'b0, -1, lat);
    n_tests++;
    if (lat !== 274) begin n_fail++; $display("FAIL row_latency got %0d expected 274", lat); end
    n_tests++;
    if (wr_cnt - w_base !== 262) begin n_fail++; $display("FAIL row_writes got %0d expected 262", wr_cnt - w_base); end
    n_tests++;
    if (lb_mem[13] !== 2'd0 || lb_mem[14] !== 2'd0 || lb_mem[10] !== 2'd1 || lb_mem[17] !== 2'd3) begin
      n_fail++; $display("FAIL row_entries e10=%0d e13=%0d e14=%0d e17=%0d expected 1 0 0 3", lb_mem[10], lb_mem[13], lb_mem[14], lb_mem[17]);
    end
    n_tests++;
    if (line_diff(1'b0) !== 0) begin n_fail++; $display("FAIL row_line bad_entries=%0d expected 0", line_diff(1'b0)); end
    disable_all();
  endtask

  task automatic test_priority();
    int lat, bad;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin rom_img[10][r][c] = 2'd1; rom_img[11][r][c] = 2'd2; end
    write_attr(5, 1'b1, 20, 0, 10);
    write_attr(0, 1'b1, 20, 0, 11);
    model_line(0);
    run_line(0, 1'b1, -1, lat);
    bad = 0;
    for (int e = 20; e < 28; e++) if (lb_mem[256 + e] !== 2'd2) bad++;
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL priority_entries wrong=%0d expected 0 (sprite 0 value 2)", bad); end
    n_tests++;
    if (wr_cnt - w_base !== 272) begin n_fail++; $display("FAIL priority_writes got %0d expected 272", wr_cnt - w_base); end
    n_tests++;
    if (lat !== 283) begin n_fail++; $display("FAIL priority_latency got %0d expected 283", lat); end
    disable_all();
  endtask

  task automatic test_clip();
    int lat;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) rom_img[7][r][c] = 2'((c % 3) + 1);
    write_attr(0, 1'b1, 252, 0, 7);
    model_line(0);
    run_line(0, 1'b0, -1, lat);
    n_tests++;
    if (wr_cnt - w_base !== 260) begin n_fail++; $display("FAIL clip_writes got %0d expected 260", wr_cnt - w_base); end
    n_tests++;
    if (low_nz - l_base !== 0) begin n_fail++; $display("FAIL clip_wrap low_entry_draws=%0d expected 0", low_nz - l_base); end
    n_tests++;
    if (line_diff(1'b0) !== 0) begin n_fail++; $display("FAIL clip_line bad_entries=%0d expected 0", line_diff(1'b0)); end
    disable_all();
  endtask

  task automatic test_wrap_overrun();
    int lat;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) rom_img[20][r][c] = (r == 3) ? 2'd3 : 2'd1;
    write_attr(2, 1'b1, 50, 1020, 20);
    model_line(3);
    run_line(3, 1'b1, 100, lat);
    n_tests++;
    if (o_Overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag got %b expected 1", o_Overrun); end
    n_tests++;
    if (lat !== 274) begin n_fail++; $display("FAIL wrap_latency got %0d expected 274", lat); end
    n_tests++;
    if (line_diff(1'b1) !== 0 || lb_mem[256 + 50] !== 2'd3) begin
      n_fail++; $display("FAIL wrap_line bad_entries=%0d e50=%0d expected 0 and 3", line_diff(1'b1), lb_mem[256 + 50]);
    end
    disable_all();
  endtask

  task automatic test_random();
    int lat, ly;
    logic sel;
    for (int t = 0; t < 5; t++) begin
      ly = int'($urandom_range(0, 1023));
      for (int s = 0; s < 8; s++)
        write_attr(s, bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
                   (ly - int'($urandom_range(0, 20)) + 1024) % 1024, int'($urandom_range(0, 63)));
      sel = 1'($urandom_range(0, 1));
      model_line(ly);
      run_line(ly, sel, -1, lat);
      n_tests++;
      if (lat !== 265 + 9 * exp_hits) begin n_fail++; $display("FAIL rand_latency t=%0d got %0d expected %0d", t, lat, 265 + 9 * exp_hits); end
      n_tests++;
      if (wr_cnt - w_base !== 256 + exp_draw) begin n_fail++; $display("FAIL rand_writes t=%0d got %0d expected %0d", t, wr_cnt - w_base, 256 + exp_draw); end
      n_tests++;
      if (line_diff(sel) !== 0) begin n_fail++; $display("FAIL rand_line t=%0d bad_entries=%0d expected 0", t, line_diff(sel)); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int keep [256];
    for (int s = 0; s < 8; s++)
      write_attr(s, 1'b1, int'($urandom_range(0, 250)), 40, int'($urandom_range(0, 63)));
    model_line(45);
    keep = exp_line;
    run_line(45, 1'b0, -1, lat);
    model_line(47);
    run_line(47, 1'b1, -1, lat);
    n_tests++;
    if (line_diff(1'b1) !== 0) begin n_fail++; $display("FAIL b2b_second bad_entries=%0d expected 0", line_diff(1'b1)); end
    exp_line = keep;
    n_tests++;
    if (line_diff(1'b0) !== 0) begin n_fail++; $display("FAIL b2b_first_kept bad_entries=%0d expected 0", line_diff(1'b0)); end
  endtask

  task automatic test_reset_mid();
    int lat;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) rom_img[30][r][c] = 2'd2;
    write_attr(7, 1'b1, 0, 200, 30);
    @(negedge clk);
    cur_sel = 1'b0; i_Line_Y = 10'd205; i_Buf_Sel = 1'b0; i_Line_Start = 1'b1;
    @(negedge clk);
    i_Line_Start = 1'b0;
    for (int k = 0; k < 262; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (o_Lb_We !== 1'b0 || o_Busy !== 1'b0 || o_Done !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs we=%b busy=%b done=%b expected 0 0 0", o_Lb_We, o_Busy, o_Done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) sh_en[i] = 1'b0;
    n_tests++;
    if (o_Overrun !== 1'b0) begin n_fail++; $display("FAIL midreset_overrun got %b expected 0", o_Overrun); end
    model_line(205);
    run_line(205, 1'b0, -1, lat);
    n_tests++;
    if (wr_cnt - w_base !== 256 || lat !== 265) begin
      n_fail++; $display("FAIL midreset_next_line writes=%0d lat=%0d expected 256 265", wr_cnt - w_base, lat);
    end
    n_tests++;
    if (line_diff(1'b0) !== 0) begin n_fail++; $display("FAIL midreset_line bad_entries=%0d expected 0", line_diff(1'b0)); end
  endtask

  initial begin
    rst = 1'b1;
    i_Attr_We = 1'b0; i_Attr_Idx = '0; i_Attr_En = 1'b0; i_Attr_X = '0; i_Attr_Y = '0; i_Attr_Num = '0;
    i_Line_Start = 1'b0; i_Line_Y = '0; i_Buf_Sel = 1'b0;
    for (int s = 0; s < 64; s++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) rom_img[s][r][c] = 2'($urandom_range(0, 3));
    for (int i = 0; i < 8; i++) begin sh_en[i] = 1'b0; sh_x[i] = 0; sh_y[i] = 0; sh_num[i] = 0; end
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_no_sprites();
    test_row_select();
    test_priority();
    test_clip();
    test_wrap_overrun();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_line_composer.md
Name: sprite_line_composer

Overview:
- Scanline sprite compositor that sits directly upstream of the line RAM.
- On each line-start pulse it clears the back half of the ping-pong line buffer, then scans an 8-entry sprite attribute table and draws every sprite that overlaps the requested row.
- Pixels are fetched from the sprite ROM and written into the line buffer, so the display side reads a finished line on the next scanline.

Parameters:
- NUM_SPRITES, 8, number of attribute table entries (power of 2).
- LB_DEPTH, 256, line buffer entries per line; one entry is 2 screen pixels.
- LB_AW, 8, line buffer address width, equal to log2(LB_DEPTH).

Ports:
- i_Clk  in  1  system clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Attr_We  in  1  attribute table write strobe.
- i_Attr_Idx  in  3  attribute entry to write.
- i_Attr_En  in  1  sprite enable.
- i_Attr_X  in  LB_AW  sprite left edge, in line-buffer units.
- i_Attr_Y  in  10  sprite top row, in screen rows.
- i_Attr_Num  in  6  sprite ROM index.
- i_Line_Start  in  1  one-cycle pulse: begin composing a line.
- i_Line_Y  in  10  screen row to compose, sampled with i_Line_Start.
- i_Buf_Sel  in  1  line buffer half to write, sampled with i_Line_Start.
- o_Rom_Sprite  out  6  sprite ROM sprite index.
- o_Rom_Row  out  3  sprite ROM row.
- o_Rom_Col  out  3  sprite ROM column.
- i_Rom_Pixel  in  2  ROM data, valid exactly one clock after its address.
- o_Lb_We  out  1  line buffer write enable.
- o_Lb_Addr  out  LB_AW+1  {half select, entry} write address.
- o_Lb_Data  out  2  line buffer write data.
- o_Busy  out  1  high from the cycle after an accepted start until DONE.
- o_Done  out  1  one-cycle pulse when the line is complete.
- o_Overrun  out  1  sticky: a start arrived while busy; cleared only by reset.

Behaviour:
- Reset (asynchronous):
  - All attribute entries have En=0; X, Y and Num are 0.
  - State is IDLE.
  - All outputs are 0.
- Attribute writes:
  - A write takes effect on the next edge, regardless of FSM state.
  - The FSM reads an entry live, in the cycle it scans that entry.
- Sprite geometry:
  - A sprite is 16 rows by 8 line-buffer entries: an 8x8 ROM image doubled in both axes.
  - dy = i_Line_Y - Y, computed mod 2^10.
  - A sprite hits the line when En=1 and dy < 16.
  - ROM row = dy[3:1].
- FSM states: IDLE, CLEAR, SCAN, FETCH, DONE.
- IDLE:
  - On i_Line_Start, latch i_Line_Y and i_Buf_Sel.
  - Set the sprite pointer to NUM_SPRITES-1 and go to CLEAR.
- CLEAR:
  - Write 0 to entries 0..LB_DEPTH-1 of the selected half, one per cycle, taking LB_DEPTH cycles.
  - Then go to SCAN.
- SCAN (1 cycle per entry):
  - On a hit, go to FETCH.
  - Otherwise decrement the pointer.
  - After entry 0 is handled, go to DONE.
- FETCH:
  - Issue ROM columns 0..7 on consecutive cycles.
  - Each returned pixel c is written one cycle later to entry X+c.
  - No write occurs when the pixel is 0 (transparent).
  - No write occurs when X+c >= LB_DEPTH: clip, no wrap-around.
  - Fetch occupies 9 cycles, then continues SCAN at the next lower index.
- Priority: sprites are scanned from high index to low, so the lower index is drawn last and wins overlaps.
- DONE: o_Done is high for 1 cycle, then go to IDLE.
- Worst case: LB_DEPTH + NUM_SPRITES × 10 + 1 = 337 cycles, which is under one 800-cycle scanline.
- i_Line_Start while not IDLE: ignored, and o_Overrun is set.
- Reset mid-line: the FSM goes to IDLE immediately and no further writes are issued. The partially written half is left as is.

Decomposition:
- Package sprite_pkg holds:
  - SPRITE_W_ENTRIES = 8 and SPRITE_H_ROWS = 16.
  - The FSM state enum.
  - The attribute record type (En, X, Y, Num).
- Sub-module sprite_attr_table: the NUM_SPRITES-entry register file with one write port and one combinational read port, reset-cleared.
- The FSM and the write pipeline stay in sprite_line_composer.

Test Plan:
1. No sprites enabled; start with Y=5, Buf_Sel=1 → exactly 256 writes of 0 to addresses 256..511, o_Done pulses 257+8 cycles after start, no other writes.
2. Sprite 0 with X=10, Y=100, Num=3, and ROM row pattern 1,2,3,0,0,1,2,3; start with Y=102 → ROM row 1 is read; non-zero pixels are written to entries 10,11,12,15,16,17; entries 13 and 14 are untouched after clear.
3. Sprites 0 and 5 both at X=20, Y=0, non-zero pixels; start with Y=0 → entries 20..27 are written by sprite 5 and then sprite 0; readback shows sprite 0 data.
4. Sprite with X=252 → only entries 252..255 are written; no write reaches address 0..3.
5. Sprite with Y=1020 and start with Y=3 → dy=7, so the sprite hits and ROM row 3 is read. A second start arriving during CLEAR is ignored and o_Overrun=1.
6. Assert i_Reset during FETCH → o_Lb_We=0, o_Busy=0 and o_Done=0 immediately; all sprites are disabled afterwards, so the next line produces clear writes only.
